apb4_ram_slave: RTL and testbench

- Parametrised APB4 completer fronting an internal register-array RAM.
- Successor to the basic APB RAM target. Adds configurable wait states, PSTRB byte-lane writes, a write-protected upper region, and PSLVERR on out-of-range or protected access.
- Sits on the TB/DUT APB bus, driven by the existing APB master driver through the APB interface.

---
 rtl/apb4_ram_slave.sv | 95 +++++++++
 tb/tb_apb4_ram_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb4_ram_slave.sv
// APB4 completer backed by a register-array RAM. It supports optional wait states and
// PSTRB byte-lane writes, and raises PSLVERR on out-of-range or write-protected access.
module apb4_ram_slave #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned RO_BASE     = 48
) (
   input  logic                    PCLK,
   input  logic                    PRESET_N,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int unsigned NB  = DATA_WIDTH / 8;
   localparam int unsigned OFF = (NB > 1) ? $clog2(NB) : 0;
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [AW-1:0]         idx_q;
   logic                  write_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx;
   logic [AW-1:0]         midx;
   logic                  oor;
   logic                  prot;
   logic                  err;

   assign idx  = PADDR >> OFF;
   assign midx = idx[AW-1:0];
   assign oor  = 32'(idx) >= DEPTH;
   assign prot = PWRITE && (32'(idx) >= RO_BASE);
   assign err  = oor || prot;

   always_ff @(posedge PCLK or negedge PRESET_N) begin
      if (!PRESET_N) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         prdata_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (PSEL && !PENABLE) begin
                  state_q <= StAccess;
                  idx_q   <= midx;
                  write_q <= PWRITE;
                  err_q   <= err;
                  cnt_q   <= 4'(WAIT_STATES);
                  // Read data is fetched at setup and held until the next read setup
                  if (!PWRITE) prdata_q <= err ? '0 : mem[midx];
               end
            end
            StAccess: begin
               if (!PSEL) begin
                  // Dropped select mid-transfer: abandon silently, nothing is written
                  state_q <= StIdle;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else if (PENABLE) begin
                  state_q <= StIdle;
                  if (write_q && !err_q) begin
                     for (int b = 0; b < int'(NB); b++) begin
                        if (PSTRB[b]) mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign PREADY  = (state_q == StAccess) && (cnt_q == 4'd0);
   assign PSLVERR = PREADY && err_q;
   assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb4_ram_slave.sv
// Randomised bench for apb4_ram_slave: three configurations on a shared bus, each with its own
// PSEL, checked against a word-array reference model.
module tb_apb4_ram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];

   int ws_cfg    [3] = '{0, 3, 2};
   int depth_cfg [3] = '{64, 64, 32};
   int ro_cfg    [3] = '{48, 48, 24};

   logic [31:0] mdl [3][64];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   apb4_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0), .RO_BASE(48))
   u_dut0 (.PCLK(clk), .PRESET_N(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
           .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
           .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb4_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3), .RO_BASE(48))
   u_dut1 (.PCLK(clk), .PRESET_N(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
           .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
           .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   apb4_ram_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(2), .RO_BASE(24))
   u_dut2 (.PCLK(clk), .PRESET_N(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
           .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
           .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 64; i++) mdl[d][i] = '0;
   endtask

   // Setup phase, then access phase held until PREADY; outputs sampled 1 time unit after edges.
   task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata);
      int          idx;
      bit          err;
      int          waits;
      logic [31:0] exp_rd;
      idx    = int'(addr) / 4;
      err    = (idx >= depth_cfg[d]) || (wr && idx >= ro_cfg[d]);
      exp_rd = err ? 32'h0 : mdl[d][idx];
      waits  = 0;
      @(posedge clk); #1;
      psel = 3'b000; psel[d] = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!pready[d] && waits < 20) begin
         check("slverr_while_waiting", 32'(pslverr[d]), 32'h0);
         waits++;
         @(posedge clk); #1;
      end
      check("wait_cycles", waits, ws_cfg[d]);
      check("pready", 32'(pready[d]), 32'h1);
      check("pslverr", 32'(pslverr[d]), 32'(err));
      if (!wr) check("prdata", prdata[d], exp_rd);
      rdata = prdata[d];
      @(posedge clk); #1;
      psel = 3'b000; penable = 1'b0;
      check("pready_after", 32'(pready[d]), 32'h0);
      if (!wr) check("prdata_hold", prdata[d], exp_rd);
      if (wr && !err)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("reset_pready", 32'(pready[d]), 32'h0);
         check("reset_pslverr", 32'(pslverr[d]), 32'h0);
         check("reset_prdata", prdata[d], 32'h0);
      end
      rst_n = 1'b1;

      // Zero wait states: full-word write then readback
      xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd);
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd);
      check("tp_deadbeef", rd, 32'hDEADBEEF);

      // Three wait states: wait_cycles check inside xfer covers the 5-cycle latency
      xfer(1, 1'b0, 8'h10, 32'h0, 4'hF, rd);

      // Byte strobes
      xfer(0, 1'b1, 8'h04, 32'h11223344, 4'hF, rd);
      xfer(0, 1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, rd);
      xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
      check("tp_strobe", rd, 32'h11BB33DD);
      xfer(0, 1'b1, 8'h04, 32'h55555555, 4'h0, rd);
      xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
      check("tp_strobe_zero", rd, 32'h11BB33DD);

      // Protected write, legal read at the top word, out-of-range read
      xfer(0, 1'b1, 8'hC0, 32'h12345678, 4'hF, rd);
      xfer(0, 1'b0, 8'hC0, 32'h0, 4'h0, rd);
      check("tp_prot_unchanged", rd, 32'h0);
      xfer(0, 1'b0, 8'hFC, 32'h0, 4'h0, rd);
      xfer(2, 1'b0, 8'hA0, 32'h0, 4'h0, rd);
      check("tp_oor_rdata", rd, 32'h0);

      // PSEL and PENABLE together while idle must not start a transfer
      @(posedge clk); #1;
      psel = 3'b001; penable = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("idle_enable_ignored", 32'(pready[0]), 32'h0);
      end
      psel = '0; penable = 1'b0;
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd);

      // Abort a write mid-access
      xfer(2, 1'b1, 8'h08, 32'h12345678, 4'hF, rd);
      @(posedge clk); #1;
      psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
      pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      check("abort_wait", 32'(pready[2]), 32'h0);
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("abort_no_pready", 32'(pready[2]), 32'h0);
      end
      xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, rd);
      check("abort_unchanged", rd, 32'h12345678);

      // Randomised traffic across all three configurations
      for (int n = 0; n < 250; n++) begin
         xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              $urandom, 4'($urandom_range(0, 15)), rd);
      end

      // Reset while PREADY is high on a read of non-zero data
      xfer(2, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, rd);
      @(posedge clk); #1;
      psel = 3'b100; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
      @(posedge clk); #1;
      penable = 1'b1;
      check("rst_pre_rdata", prdata[2], 32'hCAFEF00D);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("rst_pre_ready", 32'(pready[2]), 32'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_pready", 32'(pready[2]), 32'h0);
      check("rst_mid_pslverr", 32'(pslverr[2]), 32'h0);
      check("rst_mid_prdata", prdata[2], 32'h0);
      psel = '0; penable = 1'b0;
      clear_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, rd);
      check("rst_ram_cleared", rd, 32'h0);
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd);
      xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
      for (int n = 0; n < 30; n++) begin
         xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              $urandom, 4'($urandom_range(0, 15)), rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
